// File: rtl/alu_rs_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_pkg
// Shared definitions for the ALU reservation station: default sizing, the
// per-entry record and a small helper for CDB tag matching.
// The entry record uses TAG_W_DEFAULT for its tag fields. A build that
// overrides TAG_W on alu_rs must change TAG_W_DEFAULT here to match.
// -----------------------------------------------------------------------------
package alu_rs_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int TAG_W_DEFAULT = 7;
    localparam int ROB_W         = 3;

    typedef struct packed {
        logic                     valid;
        logic [4:0]               opcode;
        logic [2:0]               funct3;
        logic                     funct7;
        logic                     rs1_rdy;
        logic [TAG_W_DEFAULT-1:0] rs1_tag;
        logic [31:0]              rs1_data;
        logic                     rs2_rdy;
        logic [TAG_W_DEFAULT-1:0] rs2_tag;
        logic [31:0]              rs2_data;
        logic [31:0]              imm;
        logic [31:0]              pc;
        logic [ROB_W-1:0]         rob_idx;
        logic [TAG_W_DEFAULT-1:0] rd;
    } rs_entry_t;

    // A source wakes when it is still waiting and the broadcast carries its
    // producer tag. Sources that are already ready never match.
    function automatic logic src_wakes(input logic                     rdy,
                                       input logic [TAG_W_DEFAULT-1:0] tag,
                                       input logic                     cdb_valid,
                                       input logic [TAG_W_DEFAULT-1:0] cdb_tag);
        return !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

endpackage : alu_rs_pkg

// File: rtl/alu_rs_select.sv
// -----------------------------------------------------------------------------
// alu_rs_select
// Picks one ready reservation-station entry for issue.
// Configuration macro: ALU_RS_AGE_PRIO_EN
//   defined   - oldest ready entry wins (greatest age), ties to lowest index
//   undefined - lowest ready index wins
// Ports:
//   ready_i  in   DEPTH             per-entry ready flags
//   age_i    in   DEPTH x log2DEPTH per-entry ages (age priority builds only)
//   grant_o  out  DEPTH             one-hot grant, all zero when nothing ready
//   valid_o  out  1                 some entry was granted
// -----------------------------------------------------------------------------
module alu_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                      ready_i,
`ifdef ALU_RS_AGE_PRIO_EN
    input  logic [DEPTH-1:0][$clog2(DEPTH)-1:0]   age_i,
`endif
    output logic [DEPTH-1:0]                      grant_o,
    output logic                                  valid_o
);

`ifdef ALU_RS_AGE_PRIO_EN
    logic [$clog2(DEPTH)-1:0] best_age;

    // A later index replaces the current pick only when strictly older, so
    // equal ages resolve to the lowest index.
    always_comb begin
        grant_o  = '0;
        valid_o  = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && (!valid_o || (age_i[i] > best_age))) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
                best_age   = age_i[i];
            end
        end
    end
`else
    // NOTE: every variable driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && !valid_o) begin
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end
`endif

endmodule : alu_rs_select

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
// Reservation station in front of the ALU. Holds dispatched instructions
// until both sources are ready (captured at dispatch, bypassed from the CDB
// in the dispatch cycle, or woken by a later CDB broadcast), then issues one
// ready entry per cycle to an always-accepting ALU.
// Configuration macro: ALU_RS_AGE_PRIO_EN (oldest-first issue when defined,
// lowest-index-first otherwise).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash every held entry at the edge
//   dis_valid / dis_ready    dispatch handshake
//   dis_*                    decoded fields, source tags/ready/data, imm, pc,
//                            ROB slot and destination tag
//   cdb_valid/tag/data       result broadcast used for wakeup and bypass
//   alu_i_valid, alu_*       issue bundle, all zero when nothing issues
//   rs_count                 registered number of occupied entries
// -----------------------------------------------------------------------------
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    dis_valid,
    output logic                    dis_ready,
    input  logic [4:0]              dis_opcode,
    input  logic [2:0]              dis_funct3,
    input  logic                    dis_funct7,
    input  logic [TAG_W-1:0]        dis_rs1_tag,
    input  logic [TAG_W-1:0]        dis_rs2_tag,
    input  logic                    dis_rs1_rdy,
    input  logic                    dis_rs2_rdy,
    input  logic [31:0]             dis_rs1_data,
    input  logic [31:0]             dis_rs2_data,
    input  logic [31:0]             dis_imm,
    input  logic [31:0]             dis_pc,
    input  logic [2:0]              dis_rob_idx,
    input  logic [TAG_W-1:0]        dis_rd,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [31:0]             cdb_data,
    output logic                    alu_i_valid,
    output logic [4:0]              alu_opcode,
    output logic [2:0]              alu_funct3,
    output logic                    alu_funct7,
    output logic [31:0]             alu_rs1_data,
    output logic [31:0]             alu_rs2_data,
    output logic [31:0]             alu_imm,
    output logic [31:0]             alu_pc,
    output logic [2:0]              alu_i_rob_idx,
    output logic [TAG_W-1:0]        alu_i_rd,
    output logic [$clog2(DEPTH):0]  rs_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rs_entry_t          entries_q [DEPTH];
    rs_entry_t          entries_d [DEPTH];
    rs_entry_t          new_entry;
    logic [CNT_W-1:0]   rs_count_q, rs_count_d;
    logic [DEPTH-1:0]   ready_vec;
    logic [DEPTH-1:0]   grant;
    logic               sel_valid;
    logic               issue;
    logic               accept;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;

`ifdef ALU_RS_AGE_PRIO_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);
    logic [DEPTH-1:0][IDX_W-1:0] age_q, age_d;
`endif

    // Occupancy is taken from the registered count, so a slot freed by this
    // cycle's issue is only offered again next cycle.
    assign dis_ready = (rs_count_q < CNT_W'(DEPTH)) && !flush;
    assign accept    = dis_valid && dis_ready;
    assign issue     = sel_valid && !flush;
    assign rs_count  = rs_count_q;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!entries_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
        end
    end

    alu_rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i (ready_vec),
`ifdef ALU_RS_AGE_PRIO_EN
        .age_i   (age_q),
`endif
        .grant_o (grant),
        .valid_o (sel_valid)
    );

    // Incoming entry, with same-cycle bypass from the CDB for waiting sources.
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.opcode   = dis_opcode;
        new_entry.funct3   = dis_funct3;
        new_entry.funct7   = dis_funct7;
        new_entry.rs1_rdy  = dis_rs1_rdy;
        new_entry.rs1_tag  = dis_rs1_tag;
        new_entry.rs1_data = dis_rs1_data;
        new_entry.rs2_rdy  = dis_rs2_rdy;
        new_entry.rs2_tag  = dis_rs2_tag;
        new_entry.rs2_data = dis_rs2_data;
        new_entry.imm      = dis_imm;
        new_entry.pc       = dis_pc;
        new_entry.rob_idx  = dis_rob_idx;
        new_entry.rd       = dis_rd;
        if (src_wakes(dis_rs1_rdy, dis_rs1_tag, cdb_valid, cdb_tag)) begin
            new_entry.rs1_rdy  = 1'b1;
            new_entry.rs1_data = cdb_data;
        end
        if (src_wakes(dis_rs2_rdy, dis_rs2_tag, cdb_valid, cdb_tag)) begin
            new_entry.rs2_rdy  = 1'b1;
            new_entry.rs2_data = cdb_data;
        end
    end

    // Entry next state: wakeup, issue invalidation, dispatch write, flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                if (src_wakes(entries_q[i].rs1_rdy, entries_q[i].rs1_tag, cdb_valid, cdb_tag)) begin
                    entries_d[i].rs1_rdy  = 1'b1;
                    entries_d[i].rs1_data = cdb_data;
                end
                if (src_wakes(entries_q[i].rs2_rdy, entries_q[i].rs2_tag, cdb_valid, cdb_tag)) begin
                    entries_d[i].rs2_rdy  = 1'b1;
                    entries_d[i].rs2_data = cdb_data;
                end
            end
            if (issue && grant[i]) begin
                entries_d[i].valid = 1'b0;
            end
        end
        if (accept) begin
            entries_d[free_idx] = new_entry;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        rs_count_d = rs_count_q;
        if (flush) begin
            rs_count_d = '0;
        end else begin
            unique case ({accept, issue})
                2'b10: if (rs_count_q != CNT_W'(DEPTH)) rs_count_d = rs_count_q + CNT_W'(1);
                2'b01: if (rs_count_q != '0)            rs_count_d = rs_count_q - CNT_W'(1);
                default: rs_count_d = rs_count_q;
            endcase
        end
    end

`ifdef ALU_RS_AGE_PRIO_EN
    // Every accepted dispatch ages the entries already held; the new entry
    // starts at zero.
    always_comb begin
        age_d = age_q;
        if (flush) begin
            age_d = '0;
        end else if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == free_idx) begin
                    age_d[i] = '0;
                end else if (entries_q[i].valid && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end
`endif

    // NOTE: only the valid bits are reset; payload fields are don't-care while
    // an entry is invalid and are always rewritten on dispatch.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
            rs_count_q <= '0;
        end else begin
            entries_q  <= entries_d;
            rs_count_q <= rs_count_d;
        end
    end

    // Issue bundle, zero unless an entry actually issues this cycle.
    always_comb begin
        alu_i_valid   = issue;
        alu_opcode    = '0;
        alu_funct3    = '0;
        alu_funct7    = 1'b0;
        alu_rs1_data  = '0;
        alu_rs2_data  = '0;
        alu_imm       = '0;
        alu_pc        = '0;
        alu_i_rob_idx = '0;
        alu_i_rd      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && grant[i]) begin
                alu_opcode    = entries_q[i].opcode;
                alu_funct3    = entries_q[i].funct3;
                alu_funct7    = entries_q[i].funct7;
                alu_rs1_data  = entries_q[i].rs1_data;
                alu_rs2_data  = entries_q[i].rs2_data;
                alu_imm       = entries_q[i].imm;
                alu_pc        = entries_q[i].pc;
                alu_i_rob_idx = entries_q[i].rob_idx;
                alu_i_rd      = entries_q[i].rd;
            end
        end
    end

endmodule : alu_rs

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs
// Self-checking bench for alu_rs. Expected issue bundles are pushed to a
// scoreboard queue when stimulus is driven and popped when alu_i_valid is
// seen. Outputs are sampled on the falling edge; inputs change 1 time unit
// after the rising edge. Expected issue order for the age test follows
// ALU_RS_AGE_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_alu_rs;

    localparam int DEPTH = 4;
    localparam int TAG_W = 7;
    localparam logic [4:0] OP_REG = 5'h0C;
    localparam logic [4:0] OP_IMM = 5'h04;
    localparam logic [4:0] OP_LUI = 5'h0D;

    logic             clk = 1'b0;
    logic             rst, flush, dis_valid, dis_ready;
    logic [4:0]       dis_opcode;
    logic [2:0]       dis_funct3;
    logic             dis_funct7;
    logic [TAG_W-1:0] dis_rs1_tag, dis_rs2_tag, dis_rd, cdb_tag;
    logic             dis_rs1_rdy, dis_rs2_rdy, cdb_valid;
    logic [31:0]      dis_rs1_data, dis_rs2_data, dis_imm, dis_pc, cdb_data;
    logic [2:0]       dis_rob_idx;
    logic             alu_i_valid;
    logic [4:0]       alu_opcode;
    logic [2:0]       alu_funct3;
    logic             alu_funct7;
    logic [31:0]      alu_rs1_data, alu_rs2_data, alu_imm, alu_pc;
    logic [2:0]       alu_i_rob_idx;
    logic [TAG_W-1:0] alu_i_rd;
    logic [2:0]       rs_count;

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dis_valid(dis_valid), .dis_ready(dis_ready),
        .dis_opcode(dis_opcode), .dis_funct3(dis_funct3), .dis_funct7(dis_funct7),
        .dis_rs1_tag(dis_rs1_tag), .dis_rs2_tag(dis_rs2_tag),
        .dis_rs1_rdy(dis_rs1_rdy), .dis_rs2_rdy(dis_rs2_rdy),
        .dis_rs1_data(dis_rs1_data), .dis_rs2_data(dis_rs2_data),
        .dis_imm(dis_imm), .dis_pc(dis_pc),
        .dis_rob_idx(dis_rob_idx), .dis_rd(dis_rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_i_valid(alu_i_valid), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_i_rob_idx(alu_i_rob_idx),
        .alu_i_rd(alu_i_rd), .rs_count(rs_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       opcode;
        logic [2:0]       f3;
        logic             f7;
        logic [31:0]      rs1, rs2, imm, pc;
        logic [2:0]       rob;
        logic [TAG_W-1:0] rd;
    } sb_t;

    typedef struct {
        logic [4:0]       opcode;
        logic [2:0]       f3;
        logic             f7;
        logic             rs1_rdy, rs2_rdy;
        logic [TAG_W-1:0] rs1_tag, rs2_tag;
        logic [31:0]      rs1, rs2, imm, pc;
        logic [2:0]       rob;
        logic [TAG_W-1:0] rd;
        logic             cdb_v;
        logic [TAG_W-1:0] cdb_t;
        logic [31:0]      cdb_d;
        logic [31:0]      exp_rs1, exp_rs2;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    sb_t  exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Falling-edge sample: compare any issue against the scoreboard head.
    task automatic neg();
        sb_t e;
        @(negedge clk);
        if (alu_i_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got rob %0d rd %0d expected no issue (t=%0t)",
                         alu_i_rob_idx, alu_i_rd, $time);
            end else begin
                e = exp_q.pop_front();
                check("iss_opcode", 32'(alu_opcode), 32'(e.opcode));
                check("iss_funct3", 32'(alu_funct3), 32'(e.f3));
                check("iss_funct7", 32'(alu_funct7), 32'(e.f7));
                check("iss_rs1",    alu_rs1_data,    e.rs1);
                check("iss_rs2",    alu_rs2_data,    e.rs2);
                check("iss_imm",    alu_imm,         e.imm);
                check("iss_pc",     alu_pc,          e.pc);
                check("iss_rob",    32'(alu_i_rob_idx), 32'(e.rob));
                check("iss_rd",     32'(alu_i_rd),   32'(e.rd));
            end
        end else begin
            check("idle_bundle_zero",
                  32'(|{alu_opcode, alu_funct3, alu_funct7, alu_rs1_data, alu_rs2_data,
                        alu_imm, alu_pc, alu_i_rob_idx, alu_i_rd}), 32'd0);
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; dis_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        dis_opcode = '0; dis_funct3 = '0; dis_funct7 = 1'b0;
        dis_rs1_tag = '0; dis_rs2_tag = '0; dis_rs1_rdy = 1'b0; dis_rs2_rdy = 1'b0;
        dis_rs1_data = '0; dis_rs2_data = '0; dis_imm = '0; dis_pc = '0;
        dis_rob_idx = '0; dis_rd = '0;
    endtask

    task automatic cycle();
        neg();
        pos();
        idle();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Waiting entry: rs1 waits on tag, rs2 ready with value = rob.
    task automatic drive_wait(input logic [2:0] rob, input logic [TAG_W-1:0] rd,
                              input logic [TAG_W-1:0] tag);
        dis_valid = 1'b1; dis_opcode = OP_REG; dis_funct3 = 3'd0; dis_funct7 = 1'b0;
        dis_rs1_rdy = 1'b0; dis_rs1_tag = tag; dis_rs1_data = 32'hBAD0_0000 | 32'(rob);
        dis_rs2_rdy = 1'b1; dis_rs2_tag = '0;  dis_rs2_data = 32'(rob);
        dis_imm = 32'h100 + 32'(rob); dis_pc = 32'h1000 + 32'(rob) * 4;
        dis_rob_idx = rob; dis_rd = rd;
    endtask

    function automatic sb_t exp_wait(input logic [2:0] rob, input logic [TAG_W-1:0] rd,
                                     input logic [31:0] d);
        sb_t e;
        e.opcode = OP_REG; e.f3 = 3'd0; e.f7 = 1'b0;
        e.rs1 = d; e.rs2 = 32'(rob);
        e.imm = 32'h100 + 32'(rob); e.pc = 32'h1000 + 32'(rob) * 4;
        e.rob = rob; e.rd = rd;
        return e;
    endfunction

    task automatic disp_wait(input logic [2:0] rob, input logic [TAG_W-1:0] rd,
                             input logic [TAG_W-1:0] tag);
        drive_wait(rob, rd, tag);
        cycle();
    endtask

    task automatic wake(input logic [TAG_W-1:0] tag, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = d;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t e;
        int  order [4];

        // opcode f3 f7 r1rdy r2rdy r1tag r2tag rs1 rs2 imm pc rob rd cdb_v cdb_t cdb_d exp1 exp2
        vecs[0] = '{OP_REG, 3'd0, 1'b0, 1'b1, 1'b1, 7'd1, 7'd2, 32'd5, 32'd7, 32'd0, 32'h2000,
                    3'd2, 7'd9, 1'b0, 7'd0, 32'd0, 32'd5, 32'd7};
        vecs[1] = '{OP_IMM, 3'd0, 1'b0, 1'b1, 1'b1, 7'd3, 7'd0, 32'd100, 32'd0, 32'hFFFF_FFFC,
                    32'h2004, 3'd3, 7'd10, 1'b0, 7'd0, 32'd0, 32'd100, 32'd0};
        vecs[2] = '{OP_REG, 3'd0, 1'b1, 1'b1, 1'b0, 7'd4, 7'd12, 32'h30, 32'hDEAD, 32'd0,
                    32'h2008, 3'd4, 7'd11, 1'b1, 7'd12, 32'h10, 32'h30, 32'h10};
        vecs[3] = '{OP_REG, 3'd7, 1'b0, 1'b0, 1'b1, 7'd15, 7'd5, 32'hBAD, 32'd9, 32'd0,
                    32'h200C, 3'd5, 7'd12, 1'b1, 7'd15, 32'h1234, 32'h1234, 32'd9};
        vecs[4] = '{OP_REG, 3'd4, 1'b0, 1'b0, 1'b0, 7'd17, 7'd17, 32'h1, 32'h2, 32'd0,
                    32'h2010, 3'd6, 7'd13, 1'b1, 7'd17, 32'hCAFE, 32'hCAFE, 32'hCAFE};
        vecs[5] = '{OP_REG, 3'd1, 1'b0, 1'b1, 1'b1, 7'd18, 7'd18, 32'd1, 32'd2, 32'd0,
                    32'h2014, 3'd7, 7'd14, 1'b1, 7'd18, 32'h99, 32'd1, 32'd2};
        vecs[6] = '{OP_LUI, 3'd0, 1'b0, 1'b1, 1'b1, 7'd0, 7'd0, 32'd0, 32'd0, 32'h1234_5000,
                    32'h100, 3'd0, 7'd1, 1'b0, 7'd0, 32'd0, 32'd0, 32'd0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        neg();
        check("reset_count", 32'(rs_count), 32'd0);
        check("reset_dis_ready", 32'(dis_ready), 32'd1);
        check("reset_issue_valid", 32'(alu_i_valid), 32'd0);
        pos();

        // ---------------- table: dispatch, bypass, issue next cycle ----------------
        for (int k = 0; k < NV; k++) begin
            dis_valid = 1'b1;
            dis_opcode = vecs[k].opcode; dis_funct3 = vecs[k].f3; dis_funct7 = vecs[k].f7;
            dis_rs1_rdy = vecs[k].rs1_rdy; dis_rs2_rdy = vecs[k].rs2_rdy;
            dis_rs1_tag = vecs[k].rs1_tag; dis_rs2_tag = vecs[k].rs2_tag;
            dis_rs1_data = vecs[k].rs1; dis_rs2_data = vecs[k].rs2;
            dis_imm = vecs[k].imm; dis_pc = vecs[k].pc;
            dis_rob_idx = vecs[k].rob; dis_rd = vecs[k].rd;
            cdb_valid = vecs[k].cdb_v; cdb_tag = vecs[k].cdb_t; cdb_data = vecs[k].cdb_d;
            e.opcode = vecs[k].opcode; e.f3 = vecs[k].f3; e.f7 = vecs[k].f7;
            e.rs1 = vecs[k].exp_rs1; e.rs2 = vecs[k].exp_rs2;
            e.imm = vecs[k].imm; e.pc = vecs[k].pc; e.rob = vecs[k].rob; e.rd = vecs[k].rd;
            exp_q.push_back(e);
            neg();
            check("vec_count_before", 32'(rs_count), 32'd0);
            check("vec_dis_ready", 32'(dis_ready), 32'd1);
            check("vec_no_same_cycle_issue", 32'(alu_i_valid), 32'd0);
            pos();
            idle();
            neg();
            check("vec_issue_valid", 32'(alu_i_valid), 32'd1);
            check("vec_count_issue_cycle", 32'(rs_count), 32'd1);
            check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
            pos();
        end
        neg();
        check("vec_count_after", 32'(rs_count), 32'd0);
        pos();

        // ---------------- late wakeup: SUB waits on tag 12 ----------------
        dis_valid = 1'b1; dis_opcode = OP_REG; dis_funct3 = 3'd0; dis_funct7 = 1'b1;
        dis_rs1_rdy = 1'b1; dis_rs1_data = 32'h50; dis_rs2_rdy = 1'b0; dis_rs2_tag = 7'd12;
        dis_rs2_data = 32'hDEAD; dis_imm = 32'd0; dis_pc = 32'h3000; dis_rob_idx = 3'd1; dis_rd = 7'd13;
        e = '{OP_REG, 3'd0, 1'b1, 32'h50, 32'h10, 32'd0, 32'h3000, 3'd1, 7'd13};
        exp_q.push_back(e);
        cycle();
        for (int c = 1; c <= 2; c++) begin
            neg();
            check("sub_waiting", 32'(alu_i_valid), 32'd0);
            pos();
        end
        cdb_valid = 1'b1; cdb_tag = 7'd12; cdb_data = 32'h10;
        neg();
        check("sub_no_issue_on_wake", 32'(alu_i_valid), 32'd0);
        pos();
        idle();
        neg();
        check("sub_issue_after_wake", 32'(alu_i_valid), 32'd1);
        pos();
        check("sub_sb_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- full station ----------------
        for (int k = 0; k < 4; k++) disp_wait(3'(k), 7'(20 + k), 7'(50 + k));
        drive_wait(3'd4, 7'd24, 7'd54);
        neg();
        check("full_dis_ready", 32'(dis_ready), 32'd0);
        check("full_count", 32'(rs_count), 32'd4);
        pos();
        idle();
        exp_q.push_back(exp_wait(3'd1, 7'd21, 32'h51));
        wake(7'd51, 32'h51);
        neg();
        check("full_dis_ready_issue_cycle", 32'(dis_ready), 32'd0);
        check("full_count_issue_cycle", 32'(rs_count), 32'd4);
        pos();
        neg();
        check("full_dis_ready_after_issue", 32'(dis_ready), 32'd1);
        check("full_count_after_issue", 32'(rs_count), 32'd3);
        pos();
        exp_q.push_back(exp_wait(3'd0, 7'd20, 32'h50));
        wake(7'd50, 32'h50);
        exp_q.push_back(exp_wait(3'd2, 7'd22, 32'h52));
        wake(7'd52, 32'h52);
        exp_q.push_back(exp_wait(3'd3, 7'd23, 32'h53));
        wake(7'd53, 32'h53);
        drain(8);
        neg();
        check("full_count_drained", 32'(rs_count), 32'd0);
        pos();

        // ---------------- selection order: entries filled 3,1,0,2 ----------------
        disp_wait(3'd4, 7'd44, 7'd30);
        disp_wait(3'd5, 7'd45, 7'd31);
        disp_wait(3'd6, 7'd46, 7'd32);
        disp_wait(3'd3, 7'd43, 7'd20);
        exp_q.push_back(exp_wait(3'd5, 7'd45, 32'h31));
        wake(7'd31, 32'h31);
        cycle();
        disp_wait(3'd1, 7'd41, 7'd20);
        exp_q.push_back(exp_wait(3'd4, 7'd44, 32'h30));
        wake(7'd30, 32'h30);
        cycle();
        disp_wait(3'd0, 7'd40, 7'd20);
        exp_q.push_back(exp_wait(3'd6, 7'd46, 32'h32));
        wake(7'd32, 32'h32);
        cycle();
        disp_wait(3'd2, 7'd42, 7'd20);
`ifdef ALU_RS_AGE_PRIO_EN
        order = '{3, 1, 0, 2};
`else
        order = '{0, 1, 2, 3};
`endif
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_wait(3'(order[k]), 7'(40 + order[k]), 32'h20));
        wake(7'd20, 32'h20);
        drain(10);

        // ---------------- flush with concurrent dispatch and wakeup ----------------
        disp_wait(3'd0, 7'd50, 7'd70);
        disp_wait(3'd1, 7'd51, 7'd70);
        drive_wait(3'd2, 7'd52, 7'd0);
        dis_rs1_rdy = 1'b1;
        cycle();
        drive_wait(3'd3, 7'd53, 7'd0);
        dis_rs1_rdy = 1'b1;
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 7'd70; cdb_data = 32'h70;
        neg();
        check("flush_forces_no_issue", 32'(alu_i_valid), 32'd0);
        check("flush_dis_ready", 32'(dis_ready), 32'd0);
        check("flush_count_before", 32'(rs_count), 32'd3);
        pos();
        idle();
        neg();
        check("flush_count_after", 32'(rs_count), 32'd0);
        check("flush_no_issue_after", 32'(alu_i_valid), 32'd0);
        pos();
        wake(7'd70, 32'h77);
        cycle();
        cycle();
        neg();
        check("flush_count_stays_zero", 32'(rs_count), 32'd0);
        pos();

        // ---------------- reset mid-stream with two ready entries ----------------
        disp_wait(3'd0, 7'd30, 7'd80);
        disp_wait(3'd1, 7'd31, 7'd80);
        exp_q.push_back(exp_wait(3'd0, 7'd30, 32'h80));
        wake(7'd80, 32'h80);
        rst = 1'b1;
        drive_wait(3'd5, 7'd35, 7'd0);
        dis_rs1_rdy = 1'b1;
        neg();
        check("rst_two_ready_issue", 32'(alu_i_valid), 32'd1);
        check("rst_count_before", 32'(rs_count), 32'd2);
        pos();
        rst = 1'b0;
        idle();
        for (int c = 0; c < 3; c++) begin
            neg();
            check("rst_no_issue_after", 32'(alu_i_valid), 32'd0);
            check("rst_count_after", 32'(rs_count), 32'd0);
            check("rst_dis_ready_after", 32'(dis_ready), 32'd1);
            pos();
        end
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_rs

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter DEPTH, 4, number of reservation-station entries (power of two, 2..8).
REQ-002 Parameter TAG_W, 7, physical-register tag width (matches ALU rd width).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  mispredict/exception squash of all held entries.
REQ-006 dis_valid / dis_ready  input / output  1 / 1  dispatch handshake; an entry is accepted when both are high.
REQ-007 dis_opcode, dis_funct3, dis_funct7  input  5, 3, 1  decoded instruction fields.
REQ-008 dis_rs1_tag, dis_rs2_tag  input  TAG_W each  producer tags of the sources.
REQ-009 dis_rs1_rdy, dis_rs2_rdy  input  1 each  source value already valid.
REQ-010 dis_rs1_data, dis_rs2_data, dis_imm, dis_pc  input  32 each  operand values, immediate, and PC.
REQ-011 dis_rob_idx, dis_rd  input  3, TAG_W  ROB slot and destination tag.
REQ-012 cdb_valid, cdb_tag, cdb_data  input  1, TAG_W, 32  result broadcast (wakeup).
REQ-013 alu_i_valid plus alu_opcode/funct3/funct7/rs1_data/rs2_data/imm/pc/alu_i_rob_idx/alu_i_rd  output  ALU widths  issue bundle to the ALU.
REQ-014 rs_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Each entry SHALL hold: valid, all dispatch fields, and per-source ready, tag, and data.
REQ-016 dis_ready SHALL equal (registered rs_count < DEPTH) and !flush; an entry freed by issue becomes reusable only from the next cycle.
REQ-017 On accept, the block SHALL write the lowest-index free entry; the entry is eligible for issue from the next cycle at the earliest (minimum dispatch-to-issue latency 1).
REQ-018 Same-cycle bypass: if cdb_valid and cdb_tag equals a dispatched source tag with rdy=0, that source SHALL be stored ready with cdb_data.
REQ-019 Wakeup: every valid entry whose source is not ready and whose tag equals cdb_tag SHALL capture cdb_data and set ready at the edge; both sources may wake on the same broadcast.
REQ-020 A source with rdy=1 SHALL never be overwritten by CDB.
REQ-021 An entry is ready when valid and both sources are ready; I-type/LUI/AUIPC/JAL entries are dispatched with rs2_rdy=1 (and rs1_rdy=1 where rs1 is unused).
REQ-022 The ALU always accepts; when any entry is ready, alu_i_valid SHALL be 1 that cycle, the bundle SHALL be driven combinationally from the selected entry, and the entry SHALL be invalidated at the edge.
REQ-023 At most one issue and one dispatch per cycle; simultaneous issue and dispatch SHALL leave rs_count unchanged.
REQ-024 When no entry is ready, alu_i_valid=0 and all bundle fields SHALL be 0.
REQ-025 flush SHALL invalidate all entries at the edge; a dispatch or wakeup in the flush cycle is discarded; alu_i_valid SHALL be forced to 0 during flush.
REQ-026 rs_count SHALL be registered, with no overflow past DEPTH and no underflow below 0.

Reset
REQ-027 When rst=1 at the edge, all entries SHALL be invalid and rs_count 0; outputs read dis_ready=1, alu_i_valid=0, bundle 0 in the following cycle; rst overrides flush/dispatch.

Configuration
REQ-028 ALU_RS_AGE_PRIO_EN defined: each entry SHALL carry a saturating age counter (0..DEPTH-1), set to 0 on dispatch and incremented on every dispatch accept for other valid entries; selection picks the greatest age among ready entries, with ties going to the lowest index.
REQ-029 ALU_RS_AGE_PRIO_EN undefined: there SHALL be no age state, and selection is fixed priority to the lowest ready index.

Structure
REQ-030 Shared package alu_rs_pkg SHALL hold the rs_entry_t struct typedef, TAG_W, and DEPTH defaults; opcode/funct3 encodings remain in the existing define header.
REQ-031 Sub-module alu_rs_select SHALL take the ready vector (and ages when enabled) and return a one-hot grant plus a valid flag.

Verification
REQ-032 Dispatch ADD, both ready, rs1=5, rs2=7, rob 2, rd 9 at cycle 0 -> cycle 1: alu_i_valid=1, rs1_data=5, rs2_data=7, rob_idx=2, rd=9; cycle 2: rs_count=0.
REQ-033 Dispatch SUB with rs2_tag=12, rdy=0; at cycle 3 cdb_valid with tag 12, data 0x10 -> issue at cycle 4 with rs2_data=0x10; with tag 12 sent on the dispatch cycle instead -> issue next cycle (bypass).
REQ-034 Fill with 4 not-ready entries -> dis_ready=0 and rs_count=4; one wakes and issues -> dis_ready=1 the cycle after issue.
REQ-035 Entries 0..3 dispatched in order 3,1,0,2 and all woken together by tag 20 -> with age priority enabled, the issue order is 3,1,0,2; with it disabled, the order is 0,1,2,3.
REQ-036 Three valid entries, flush at cycle 5 concurrent with dispatch and a CDB wakeup -> cycle 6: rs_count=0, alu_i_valid=0, no issue of any flushed rob_idx.
REQ-037 rst asserted mid-stream with 2 ready entries -> no issue after the reset edge, and rs_count=0.
